// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared single-cycle ALU.
// Holds each result until the consumer takes it and keeps the architectural flag register.
module alu_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [2:0]  req0_op,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic        req1_ready,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  output logic [2:0]  alu_op,
  output logic [2:0]  alu_flag_in,
  input  logic [15:0] alu_out,
  input  logic [2:0]  alu_flag,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic [2:0]  rsp_flag,
  input  logic        rsp_ready,
  input  logic        flag_clr,
  output logic [2:0]  flag_q
);

  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;

  state_t      state;
  logic        last_grant;
  logic [15:0] a_q;
  logic [15:0] b_q;
  logic [2:0]  op_q;
  logic        id_q;
  logic        any_valid;
  logic        grant_id;

  // On a tie the requester that did not win last time gets the ALU.
  always_comb begin
    any_valid  = req0_valid | req1_valid;
    grant_id   = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (!rst && state == IDLE && any_valid) begin
      req0_ready = ~grant_id;
      req1_ready = grant_id;
    end
  end

  assign alu_in1     = a_q;
  assign alu_in2     = b_q;
  assign alu_op      = op_q;
  assign alu_flag_in = flag_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      a_q        <= 16'h0000;
      b_q        <= 16'h0000;
      op_q       <= 3'b000;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= 16'h0000;
      rsp_flag   <= 3'b000;
      flag_q     <= 3'b000;
    end else begin
      case (state)
        IDLE: begin
          if (flag_clr) flag_q <= 3'b000;
          if (any_valid) begin
            a_q        <= grant_id ? req1_a  : req0_a;
            b_q        <= grant_id ? req1_b  : req0_b;
            op_q       <= grant_id ? req1_op : req0_op;
            id_q       <= grant_id;
            last_grant <= grant_id;
            state      <= EXEC;
          end
        end
        // The ALU flag update wins over a simultaneous flag_clr here.
        EXEC: begin
          rsp_result <= alu_out;
          rsp_flag   <= alu_flag;
          flag_q     <= alu_flag;
          rsp_id     <= id_q;
          rsp_valid  <= 1'b1;
          state      <= HOLD;
        end
        HOLD: begin
          if (flag_clr) flag_q <= 3'b000;
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: a behavioural ALU stub, a vector table and
// hand-written sequences for stall, reset-abort, flag-clear and round-robin cases.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic [15:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        req0_ready, req1_ready;
  logic [15:0] alu_in1, alu_in2, alu_out;
  logic [2:0]  alu_op, alu_flag_in, alu_flag;
  logic        rsp_valid, rsp_id, rsp_ready, flag_clr;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_flag, flag_q;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        v0;
    logic        v1;
    logic [15:0] a0;
    logic [15:0] b0;
    logic [2:0]  op0;
    logic [15:0] a1;
    logic [15:0] b1;
    logic [2:0]  op1;
    logic        exp_id;
    logic [15:0] exp_result;
    logic [2:0]  exp_flag;
  } vec_t;

  typedef struct {
    logic        id;
    logic [15:0] result;
    logic [2:0]  flag;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[7];

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op), .req1_ready(req1_ready),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_flag_in(alu_flag_in),
    .alu_out(alu_out), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_flag(rsp_flag),
    .rsp_ready(rsp_ready), .flag_clr(flag_clr), .flag_q(flag_q)
  );

  always #5 clk = ~clk;

  // Shared ALU stand-in; flags packed as {Z,V,N}.
  function automatic logic [18:0] alu_model(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    logic [15:0] r;
    logic        v;
    v = 1'b0;
    case (op)
      3'b000: begin r = a + b; v = (a[15] == b[15]) && (r[15] != a[15]); end
      3'b001: begin r = a - b; v = (a[15] != b[15]) && (r[15] != a[15]); end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b100: r = a ^ b;
      default: r = a;
    endcase
    return {(r == 16'h0000), v, r[15], r};
  endfunction

  always_comb {alu_flag, alu_out} = alu_model(alu_in1, alu_in2, alu_op);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v0, input logic v1,
                               input logic [15:0] a0, input logic [15:0] b0, input logic [2:0] op0,
                               input logic [15:0] a1, input logic [15:0] b1, input logic [2:0] op1);
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 1'b0, 16'h0, 16'h0, 3'b0, 16'h0, 16'h0, 3'b0);
  endtask

  task automatic scoreboardCheck(input logic check_flag_q);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL sb_underflow actual=response expected=none at %0t", $time);
    end else begin
      e = sb.pop_front();
      checkOutput("rsp_id", 16'(rsp_id), 16'(e.id));
      checkOutput("rsp_result", rsp_result, e.result);
      checkOutput("rsp_flag", 16'(rsp_flag), 16'(e.flag));
      if (check_flag_q) checkOutput("flag_q", 16'(flag_q), 16'(e.flag));
      checkOutput("alu_flag_in", 16'(alu_flag_in), 16'(flag_q));
    end
  endtask

  task automatic doReset();
    rst = 1'b1;
    rsp_ready = 1'b0;
    flag_clr = 1'b0;
    applyStimulus(1'b1, 1'b1, 16'h1111, 16'h2222, 3'b001, 16'h3333, 16'h4444, 3'b010);
    #1;
    checkOutput("rst_req0_ready", 16'(req0_ready), 16'h0);
    checkOutput("rst_req1_ready", 16'(req1_ready), 16'h0);
    tick();
    tick();
    rst = 1'b0;
    idleInputs();
    sb.delete();
  endtask

  // One full operation: accept, execute, check latency and response, consume.
  task automatic runOp(input vec_t v);
    int lat;
    exp_t e;
    rsp_ready = 1'b0;
    applyStimulus(v.v0, v.v1, v.a0, v.b0, v.op0, v.a1, v.b1, v.op1);
    #1;
    checkOutput("grant_req0_ready", 16'(req0_ready), 16'(!v.exp_id));
    checkOutput("grant_req1_ready", 16'(req1_ready), 16'(v.exp_id));
    if (req0_ready || req1_ready) begin
      e.id = v.exp_id; e.result = v.exp_result; e.flag = v.exp_flag;
      sb.push_back(e);
    end
    tick();
    idleInputs();
    #1;
    checkOutput("exec_ready", 16'({req0_ready, req1_ready}), 16'h0);
    checkOutput("alu_in1", alu_in1, v.exp_id ? v.a1 : v.a0);
    checkOutput("alu_op", 16'(alu_op), 16'(v.exp_id ? v.op1 : v.op0));
    lat = 1;
    while (!rsp_valid && lat < 8) begin
      tick();
      lat++;
    end
    checkOutput("latency", 16'(lat), 16'd2);
    if (rsp_valid) scoreboardCheck(1'b1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checkOutput("rsp_valid_cleared", 16'(rsp_valid), 16'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    logic order[3];
    int grants;
    int resps;
    exp_t e;

    vecs[0] = '{1'b1, 1'b0, 16'h7FFF, 16'h0001, 3'b000, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'h8000, 3'b011};
    vecs[1] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 3'b000, 16'h0005, 16'hFFFB, 3'b000, 1'b1, 16'h0000, 3'b100};
    vecs[2] = '{1'b1, 1'b1, 16'h00F0, 16'h0F0F, 3'b010, 16'hFFFF, 16'hFFFF, 3'b000, 1'b0, 16'h0000, 3'b100};
    vecs[3] = '{1'b1, 1'b1, 16'h1234, 16'h1111, 3'b000, 16'h8000, 16'h0001, 3'b001, 1'b1, 16'h7FFF, 3'b010};
    vecs[4] = '{1'b1, 1'b0, 16'h0003, 16'h0005, 3'b001, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'hFFFE, 3'b001};
    vecs[5] = '{1'b1, 1'b0, 16'hAAAA, 16'h5555, 3'b011, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'hFFFF, 3'b001};
    vecs[6] = '{1'b1, 1'b1, 16'h0001, 16'h0001, 3'b000, 16'h1234, 16'h1234, 3'b100, 1'b1, 16'h0000, 3'b100};

    doReset();
    checkOutput("reset_rsp_valid", 16'(rsp_valid), 16'h0);
    checkOutput("reset_rsp_id", 16'(rsp_id), 16'h0);
    checkOutput("reset_rsp_result", rsp_result, 16'h0000);
    checkOutput("reset_rsp_flag", 16'(rsp_flag), 16'h0);
    checkOutput("reset_flag_q", 16'(flag_q), 16'h0);
    checkOutput("reset_alu_in1", alu_in1, 16'h0000);
    checkOutput("reset_alu_in2", alu_in2, 16'h0000);
    checkOutput("reset_alu_op", 16'(alu_op), 16'h0);

    for (int i = 0; i < 7; i++) runOp(vecs[i]);

    // Both requesters held valid with a consumer that is always ready.
    doReset();
    rsp_ready = 1'b1;
    grants = 0;
    resps = 0;
    for (int cyc = 0; cyc < 40 && resps < 3; cyc++) begin
      if (grants < 3)
        applyStimulus(1'b1, 1'b1, 16'h7FFF, 16'h0001, 3'b000, 16'h0005, 16'hFFFB, 3'b000);
      else
        idleInputs();
      #1;
      checkOutput("rr_one_hot", 16'(req0_ready & req1_ready), 16'h0);
      if ((req0_ready || req1_ready) && grants < 3) begin
        order[grants] = req1_ready;
        e.id = req1_ready;
        e.result = req1_ready ? 16'h0000 : 16'h8000;
        e.flag = req1_ready ? 3'b100 : 3'b011;
        sb.push_back(e);
        grants++;
      end
      if (rsp_valid) begin
        scoreboardCheck(1'b1);
        resps++;
      end
      tick();
    end
    rsp_ready = 1'b0;
    checkOutput("rr_responses", 16'(resps), 16'd3);
    checkOutput("rr_grants", 16'(grants), 16'd3);
    if (grants == 3) begin
      checkOutput("rr_order0", 16'(order[0]), 16'h0);
      checkOutput("rr_order1", 16'(order[1]), 16'h1);
      checkOutput("rr_order2", 16'(order[2]), 16'h0);
    end

    // Consumer stalls for five cycles while another requester waits.
    applyStimulus(1'b1, 1'b0, 16'h0010, 16'h0003, 3'b001, 16'h0000, 16'h0000, 3'b000);
    #1;
    checkOutput("stall_req0_ready", 16'(req0_ready), 16'h1);
    e.id = 1'b0; e.result = 16'h000D; e.flag = 3'b000;
    if (req0_ready) sb.push_back(e);
    tick();
    idleInputs();
    tick();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1, 16'h0000, 16'h0000, 3'b000, 16'h0001, 16'h0002, 3'b000);
      #1;
      checkOutput("stall_rsp_valid", 16'(rsp_valid), 16'h1);
      checkOutput("stall_rsp_result", rsp_result, 16'h000D);
      checkOutput("stall_rsp_id", 16'(rsp_id), 16'h0);
      checkOutput("stall_rsp_flag", 16'(rsp_flag), 16'h0);
      checkOutput("stall_ready", 16'({req0_ready, req1_ready}), 16'h0);
      tick();
    end
    idleInputs();
    rsp_ready = 1'b1;
    scoreboardCheck(1'b1);
    tick();
    rsp_ready = 1'b0;
    checkOutput("stall_consumed", 16'(rsp_valid), 16'h0);
    req1_valid = 1'b1;
    #1;
    checkOutput("stall_back_to_idle", 16'(req1_ready), 16'h1);
    req1_valid = 1'b0;
    #1;

    // Reset during EXEC abandons the operation.
    tick();
    applyStimulus(1'b1, 1'b0, 16'h7FFF, 16'h0001, 3'b000, 16'h0000, 16'h0000, 3'b000);
    tick();
    idleInputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    checkOutput("abort_rsp_valid", 16'(rsp_valid), 16'h0);
    checkOutput("abort_flag_q", 16'(flag_q), 16'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("abort_no_rsp", 16'(rsp_valid), 16'h0);
    end
    v = '{1'b1, 1'b0, 16'h0005, 16'hFFFB, 3'b000, 16'h0000, 16'h0000, 3'b000, 1'b0, 16'h0000, 3'b100};
    runOp(v);

    // flag_clr loses to the EXEC flag update but clears in HOLD.
    doReset();
    applyStimulus(1'b1, 1'b0, 16'h7FFF, 16'h0001, 3'b000, 16'h0000, 16'h0000, 3'b000);
    #1;
    e.id = 1'b0; e.result = 16'h8000; e.flag = 3'b011;
    if (req0_ready) sb.push_back(e);
    tick();
    idleInputs();
    flag_clr = 1'b1;
    tick();
    checkOutput("clr_exec_flag_q", 16'(flag_q), 16'h3);
    tick();
    flag_clr = 1'b0;
    checkOutput("clr_hold_flag_q", 16'(flag_q), 16'h0);
    checkOutput("clr_hold_rsp_valid", 16'(rsp_valid), 16'h1);
    rsp_ready = 1'b1;
    scoreboardCheck(1'b0);
    tick();
    rsp_ready = 1'b0;
    checkOutput("clr_consumed", 16'(rsp_valid), 16'h0);

    checkOutput("sb_empty", 16'(sb.size()), 16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL run on one clock and use a synchronous, active-high reset: clk and rst.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 reqN_valid  input  1  (N=0,1) requester N presents an operation.
REQ-005 reqN_a, reqN_b  input  16 each  requester N operands.
REQ-006 reqN_op  input  3  requester N ALU opcode, passed unmodified.
REQ-007 reqN_ready  output  1  requester N operation accepted this cycle.
REQ-008 alu_in1, alu_in2  output  16 each  operands driven to the shared ALU.
REQ-009 alu_op  output  3  opcode driven to the shared ALU.
REQ-010 alu_flag_in  output  3  current flag register driven to ALU FLAG_in.
REQ-011 alu_out  input  16  ALU result.
REQ-012 alu_flag  input  3  ALU flags; bit0 N, bit1 V, bit2 Z.
REQ-013 rsp_valid  output  1  response held.
REQ-014 rsp_id  output  1  index of the requester that owns the response.
REQ-015 rsp_result  output  16  captured ALU result.
REQ-016 rsp_flag  output  3  captured ALU flags.
REQ-017 rsp_ready  input  1  consumer accepts the response.
REQ-018 flag_clr  input  1  clears the flag register.
REQ-019 flag_q  output  3  architectural flag register {Z,V,N}.

Function
REQ-020 The FSM SHALL have states IDLE, EXEC, HOLD.
REQ-021 In IDLE, with any reqN_valid high, the arbiter SHALL grant exactly one requester, assert only its reqN_ready combinationally, latch its a/b/op/id, and move to EXEC.
REQ-022 Arbitration SHALL be round-robin: on simultaneous valids, the requester not granted last wins; last_grant SHALL reset to 1 so req0 wins the first tie.
REQ-023 A single valid requester SHALL be granted regardless of last_grant.
REQ-024 reqN_ready SHALL be 0 in EXEC and HOLD and in IDLE when the requester is not granted.
REQ-025 alu_in1/alu_in2/alu_op SHALL always reflect the latched operand registers; alu_flag_in SHALL always equal flag_q.
REQ-026 In EXEC, on the clock edge, the block SHALL capture alu_out into rsp_result, alu_flag into rsp_flag and into flag_q, set rsp_valid, and move to HOLD.
REQ-027 In HOLD, rsp_valid, rsp_id, rsp_result, rsp_flag SHALL stay stable until rsp_ready=1; on that edge rsp_valid clears and the FSM returns to IDLE.
REQ-028 Latency SHALL be: accept at cycle T, rsp_valid high from cycle T+2; minimum issue interval 3 cycles per operation.
REQ-029 flag_clr SHALL clear flag_q to 000 at the next edge in IDLE or HOLD; in EXEC the ALU flag update SHALL take priority over flag_clr.
REQ-030 rsp_ready while rsp_valid=0 SHALL be ignored.
REQ-031 Operations SHALL never be dropped or duplicated: each accepted request produces exactly one response with the matching rsp_id.

Reset
REQ-032 rst=1 SHALL force IDLE, rsp_valid=0, rsp_id=0, rsp_result=0000h, rsp_flag=000, flag_q=000, operand/op registers 0, last_grant=1, all reqN_ready=0.
REQ-033 rst asserted in EXEC or HOLD SHALL abandon the in-flight operation with no response and no flag_q update.
REQ-034 rst SHALL take priority over every other input in the same cycle.

Verification
REQ-035 req0: a=7FFFh, b=0001h, op=000, flag_q=000 -> req0_ready at T, rsp_valid at T+2, rsp_result=8000h, rsp_flag=011, rsp_id=0, flag_q=011.
REQ-036 Both valid in IDLE after reset, then both remain valid -> grants req0, then req1, then req0; rsp_id sequence 0,1,0.
REQ-037 req1: a=0005h, b=FFFBh, op=000 with flag_q=000 -> rsp_result=0000h, rsp_flag=100, rsp_id=1.
REQ-038 rsp_ready held 0 for 5 cycles in HOLD -> rsp_* stable, no reqN_ready asserted; response consumed on first rsp_ready=1, IDLE next cycle.
REQ-039 rst pulsed in EXEC -> next cycle rsp_valid=0, flag_q=000, no response appears; following req0 accepted normally.
REQ-040 flag_clr=1 in the EXEC cycle of an op producing 011 -> flag_q=011; flag_clr=1 in HOLD -> flag_q=000, rsp_flag still 011.
